// File: rtl/rx_frame_wr16_if.sv
// Stream, buffer port A and frame status signals of the rx_frame_wr16 write stage.
// slave is the write stage's view; master is the view of whatever drives it.
interface rx_frame_wr16_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  s_valid;
    logic [15:0]           s_data;
    logic                  s_last;
    logic [1:0]            s_keep;
    logic                  s_ready;

    logic                  mem_en;
    logic [1:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_din;

    logic                  frame_done;
    logic [ADDR_WIDTH+1:0] frame_len;
    logic                  frame_err;
    logic                  busy;
    logic                  buf_release;

    modport slave (
        input  s_valid, s_data, s_last, s_keep, buf_release,
        output s_ready, mem_en, mem_we, mem_addr, mem_din,
               frame_done, frame_len, frame_err, busy
    );

    modport master (
        output s_valid, s_data, s_last, s_keep, buf_release,
        input  s_ready, mem_en, mem_we, mem_addr, mem_din,
               frame_done, frame_len, frame_err, busy
    );
endinterface

// File: rtl/rx_frame_wr16.sv
// Writes a 16-bit valid/ready frame stream into buffer port A and holds the frame until released.
// Optional idle timeout in FILL/DROP is built when RX_FRAME_WR16_TIMEOUT_EN is defined.
module rx_frame_wr16 #(
    parameter int ADDR_WIDTH = 13,
    parameter int MAX_WORDS  = 8192,
    parameter int TIMEOUT    = 1024
) (
    input  logic           clk,
    input  logic           rstn,
    rx_frame_wr16_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam int LW = ADDR_WIDTH + 2;
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_WORDS - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(2 * MAX_WORDS);

    if (MAX_WORDS < 1 || MAX_WORDS > (1 << ADDR_WIDTH) || TIMEOUT < 1) begin : g_bad_cfg
        $error("rx_frame_wr16: MAX_WORDS must be 1..2**ADDR_WIDTH and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, FILL, DROP, DONE} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_mem_en;
    logic [1:0]            r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [15:0]           r_mem_din;
    logic [PW-1:0]         r_wr_ptr;
    logic [LW-1:0]         r_len;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_at_end;
    logic                  w_half;
    logic                  w_write;
    logic                  w_start;
    logic                  w_overflow;
    logic                  w_timeout;
    logic [LW-1:0]         w_len_sum;

    assign w_accept  = bus.s_valid & r_ready;
    assign w_at_end  = (r_wr_ptr == LAST_PTR);
    assign w_half    = bus.s_last & (bus.s_keep == 2'b01);
    assign w_len_sum = (w_start ? '0 : r_len) + (w_half ? LW'(1) : LW'(2));

`ifdef RX_FRAME_WR16_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_idle_cnt;
    logic          w_counting;

    assign w_counting = (r_state == FILL) || (r_state == DROP);
    assign w_timeout  = w_counting & ~bus.s_valid & (r_idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idle_cnt <= '0;
        end else if (!w_counting || bus.s_valid) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A beat written at the last buffer slot without s_last is the overflow point.
    always_comb begin
        w_next_state = r_state;
        w_write      = 1'b0;
        w_start      = 1'b0;
        w_overflow   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    w_start = 1'b1;
                    if (bus.s_last) begin
                        w_next_state = DONE;
                    end else if (w_at_end) begin
                        w_next_state = DROP;
                        w_overflow   = 1'b1;
                    end else begin
                        w_next_state = FILL;
                    end
                end
            end
            FILL: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    if (bus.s_last) begin
                        w_next_state = DONE;
                    end else if (w_at_end) begin
                        w_next_state = DROP;
                        w_overflow   = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next_state = DONE;
                end
            end
            DROP: begin
                if (w_accept && bus.s_last) begin
                    w_next_state = DONE;
                end else if (w_timeout) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (bus.buf_release) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 2'b00;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_wr_ptr   <= '0;
            r_len      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_ready  <= (w_next_state != DONE);
            r_busy   <= (w_next_state == DONE);
            r_done   <= (w_next_state == DONE) && (r_state != DONE);
            r_mem_en <= w_write;
            r_mem_we <= w_write ? (w_half ? 2'b01 : 2'b11) : 2'b00;
            if (w_write) begin
                r_mem_addr <= r_wr_ptr[ADDR_WIDTH-1:0];
                r_mem_din  <= bus.s_data;
                r_len      <= (w_len_sum > LEN_MAX) ? LEN_MAX : w_len_sum;
            end
            if (r_state == DONE && bus.buf_release) begin
                r_wr_ptr <= '0;
            end else if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // Status from the previous frame stays visible until this frame's first write.
            if (w_start) begin
                r_err <= w_overflow;
            end else if (w_overflow || w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.s_ready    = r_ready;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign bus.frame_done = r_done;
    assign bus.frame_len  = r_len;
    assign bus.frame_err  = r_err;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_rx_frame_wr16.sv
// Bench for rx_frame_wr16 with a 4-halfword buffer and an 8-cycle idle timeout.
// Writes are logged by a monitor and compared with a frame-level model of the expected buffer contents.
module tb_rx_frame_wr16;
    localparam int AW   = 13;
    localparam int MAXW = 4;
    localparam int TMO  = 8;
    localparam int LW   = AW + 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    we;
        logic [15:0]   din;
    } wr_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rx_frame_wr16_if #(.ADDR_WIDTH(AW)) bus();

    rx_frame_wr16 #(
        .ADDR_WIDTH(AW),
        .MAX_WORDS (MAXW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int            testsRun    = 0;
    int            testsFailed = 0;
    logic [15:0]   beatData[16];
    wr_t           wrQ[$];
    wr_t           expQ[$];
    int            doneCount   = 0;
    logic [LW-1:0] doneLen;
    logic          doneErr;
    logic          doneWithWrite;
    logic [LW-1:0] expLen;
    logic          expErr;
    logic          expDoneWithWrite;

    // Log every buffer write and the status captured at each frame_done pulse.
    always @(negedge clk) begin
        if (bus.mem_en) wrQ.push_back({bus.mem_addr, bus.mem_we, bus.mem_din});
        if (bus.frame_done) begin
            doneCount++;
            doneLen       = bus.frame_len;
            doneErr       = bus.frame_err;
            doneWithWrite = bus.mem_en;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Buffer image of a frame of n beats: only the first MAXW beats land, at addresses 0..
    task automatic buildExpected(input int n, input logic [1:0] lastKeep);
        int  nw;
        int  bytes;
        wr_t e;
        expQ.delete();
        bytes = 0;
        nw = (n > MAXW) ? MAXW : n;
        for (int i = 0; i < nw; i++) begin
            e.addr = AW'(i);
            e.din  = beatData[i];
            e.we   = (i == n - 1 && lastKeep == 2'b01) ? 2'b01 : 2'b11;
            bytes += (e.we == 2'b01) ? 1 : 2;
            expQ.push_back(e);
        end
        if (bytes > 2 * MAXW) bytes = 2 * MAXW;
        expLen           = LW'(bytes);
        expErr           = (n > MAXW);
        expDoneWithWrite = (n <= MAXW);
    endtask

    task automatic sendFrame(input int n, input bit withLast, input logic [1:0] lastKeep,
                             input bit gaps, output bit ok);
        int   guard;
        logic acc;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = beatData[i];
            bus.s_last  = withLast && (i == n - 1);
            bus.s_keep  = bus.s_last ? lastKeep : 2'($urandom_range(0, 3));
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 100) begin
                @(negedge clk);
                acc = bus.s_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
            if (!acc) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic waitDone(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (doneCount >= target) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (doneCount >= target) ok = 1'b1;
    endtask

    task automatic doRelease();
        bus.buf_release = 1'b1;
        @(posedge clk);
        #1;
        bus.buf_release = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        testsRun++;
        if ({bus.s_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din, bus.frame_done,
             bus.frame_len, bus.frame_err, bus.busy} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset outputs got %h want 0", {bus.s_ready, bus.mem_en, bus.mem_we,
                     bus.mem_addr, bus.mem_din, bus.frame_done, bus.frame_len, bus.frame_err, bus.busy});
        end
        rstn = 1'b1;
        #1;
        testsRun++;
        if (bus.s_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL ready before edge got %b want 0", bus.s_ready); end
        @(posedge clk);
        #1;
        testsRun++;
        if (bus.s_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL ready after edge got %b want 1", bus.s_ready); end
    endtask

    task automatic test_three_beat();
        int d0;
        bit ok;
        beatData[0] = 16'h1122; beatData[1] = 16'h3344; beatData[2] = 16'h5566;
        buildExpected(3, 2'b11);
        wrQ.delete();
        d0 = doneCount;
        sendFrame(3, 1'b1, 2'b11, 1'b0, ok);
        testsRun++;
        if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL three send stalled got %b want 1", ok); end
        waitDone(d0 + 1, 20, ok);
        testsRun++;
        if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL three no done got %0d want %0d", doneCount, d0 + 1); end
        testsRun++;
        if (wrQ.size() != 3) begin testsFailed++; $display("[TB] FAIL three writes got %0d want 3", wrQ.size()); end
        for (int i = 0; i < 3; i++) begin
            wr_t got = '0;
            if (i < wrQ.size()) got = wrQ[i];
            testsRun++;
            if (got !== expQ[i]) begin testsFailed++; $display("[TB] FAIL three write%0d got %h want %h", i, got, expQ[i]); end
        end
        testsRun++;
        if ({doneLen, doneErr, doneWithWrite} !== {LW'(6), 1'b0, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL three status len=%0d err=%b wr=%b want len=6 err=0 wr=1", doneLen, doneErr, doneWithWrite);
        end
        repeat (3) begin @(posedge clk); #1; end
        testsRun++;
        if ({doneCount == d0 + 1, bus.s_ready, bus.busy} !== 3'b101) begin
            testsFailed++;
            $display("[TB] FAIL three hold dones=%0d ready=%b busy=%b want dones=%0d ready=0 busy=1",
                     doneCount - d0, bus.s_ready, bus.busy, 1);
        end
        doRelease();
    endtask

    task automatic test_single_beat();
        int d0;
        bit ok;
        beatData[0] = 16'h00AB;
        wrQ.delete();
        d0 = doneCount;
        sendFrame(1, 1'b1, 2'b01, 1'b0, ok);
        testsRun++;
        if (bus.s_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL single direct done ready got %b want 0", bus.s_ready); end
        waitDone(d0 + 1, 20, ok);
        testsRun++;
        if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL single no done got %0d want %0d", doneCount, d0 + 1); end
        testsRun++;
        if (wrQ.size() != 1 || wrQ[0] !== wr_t'({AW'(0), 2'b01, 16'h00AB})) begin
            testsFailed++;
            $display("[TB] FAIL single write count=%0d first=%h want 1 write addr0 we01 00ab",
                     wrQ.size(), (wrQ.size() > 0) ? wrQ[0] : wr_t'('0));
        end
        testsRun++;
        if ({doneLen, doneErr} !== {LW'(1), 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL single status len=%0d err=%b want len=1 err=0", doneLen, doneErr);
        end
        doRelease();
    endtask

    task automatic test_overflow();
        int d0;
        bit ok;
        for (int i = 0; i < 6; i++) beatData[i] = 16'($urandom);
        buildExpected(6, 2'b11);
        wrQ.delete();
        d0 = doneCount;
        sendFrame(6, 1'b1, 2'b11, 1'b0, ok);
        waitDone(d0 + 1, 20, ok);
        testsRun++;
        if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL overflow no done got %0d want %0d", doneCount, d0 + 1); end
        testsRun++;
        if (wrQ.size() != 4) begin testsFailed++; $display("[TB] FAIL overflow writes got %0d want 4", wrQ.size()); end
        for (int i = 0; i < 4; i++) begin
            wr_t got = '0;
            if (i < wrQ.size()) got = wrQ[i];
            testsRun++;
            if (got !== expQ[i]) begin testsFailed++; $display("[TB] FAIL overflow write%0d got %h want %h", i, got, expQ[i]); end
        end
        testsRun++;
        if ({doneLen, doneErr, doneWithWrite} !== {LW'(8), 1'b1, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL overflow status len=%0d err=%b wr=%b want len=8 err=1 wr=0", doneLen, doneErr, doneWithWrite);
        end
        doRelease();
    endtask

    task automatic test_back_to_back();
        int d0;
        int n0;
        bit ok;
        bit bad;
        beatData[0] = 16'hA001; beatData[1] = 16'hA002; beatData[2] = 16'hA003;
        d0 = doneCount;
        sendFrame(3, 1'b1, 2'b11, 1'b0, ok);
        waitDone(d0 + 1, 20, ok);
        testsRun++;
        if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b no done got %0d want %0d", doneCount, d0 + 1); end
        wrQ.delete();
        bad = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'hDEAD;
        bus.s_last  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.s_ready !== 1'b0 || bus.mem_en !== 1'b0) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        n0 = wrQ.size();
        testsRun++;
        if (bad !== 1'b0 || n0 != 0) begin
            testsFailed++;
            $display("[TB] FAIL b2b backpressure stray=%b writes=%0d want stray=0 writes=0", bad, n0);
        end
        doRelease();
        testsRun++;
        if ({bus.busy, bus.s_ready, bus.frame_len} !== {1'b0, 1'b1, LW'(6)}) begin
            testsFailed++;
            $display("[TB] FAIL b2b release busy=%b ready=%b len=%0d want busy=0 ready=1 len=6",
                     bus.busy, bus.s_ready, bus.frame_len);
        end
        beatData[0] = 16'hB001; beatData[1] = 16'hB002;
        wrQ.delete();
        d0 = doneCount;
        sendFrame(2, 1'b1, 2'b11, 1'b0, ok);
        waitDone(d0 + 1, 20, ok);
        testsRun++;
        if (wrQ.size() < 1 || wrQ[0].addr !== AW'(0) || wrQ[0].din !== 16'hB001) begin
            testsFailed++;
            $display("[TB] FAIL b2b next frame first write count=%0d first=%h want addr0 b001",
                     wrQ.size(), (wrQ.size() > 0) ? wrQ[0] : wr_t'('0));
        end
        doRelease();
    endtask

    task automatic test_reset_midframe();
        int d0;
        bit ok;
        beatData[0] = 16'hC001; beatData[1] = 16'hC002;
        d0 = doneCount;
        sendFrame(2, 1'b0, 2'b11, 1'b0, ok);
        #2;
        rstn = 1'b0;
        #1;
        testsRun++;
        if ({bus.s_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din, bus.frame_done,
             bus.frame_len, bus.frame_err, bus.busy} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL midreset outputs got %h want 0", {bus.s_ready, bus.mem_en, bus.mem_we,
                     bus.mem_addr, bus.mem_din, bus.frame_done, bus.frame_len, bus.frame_err, bus.busy});
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        beatData[0] = 16'hD001; beatData[1] = 16'hD002; beatData[2] = 16'hD003;
        wrQ.delete();
        sendFrame(3, 1'b1, 2'b11, 1'b0, ok);
        waitDone(d0 + 1, 20, ok);
        repeat (3) begin @(posedge clk); #1; end
        testsRun++;
        if (doneCount != d0 + 1) begin
            testsFailed++;
            $display("[TB] FAIL midreset done count got %0d want %0d", doneCount - d0, 1);
        end
        testsRun++;
        if (wrQ.size() != 3 || wrQ[0].addr !== AW'(0) || doneLen !== LW'(6)) begin
            testsFailed++;
            $display("[TB] FAIL midreset restart writes=%0d first=%h len=%0d want 3 writes addr0 len=6",
                     wrQ.size(), (wrQ.size() > 0) ? wrQ[0] : wr_t'('0), doneLen);
        end
        doRelease();
    endtask

    task automatic test_random();
        int          d0;
        int          n;
        bit          ok;
        logic [1:0]  lk;
        for (int f = 0; f < 25; f++) begin
            n  = $urandom_range(1, 7);
            lk = 2'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) beatData[i] = 16'($urandom);
            buildExpected(n, lk);
            wrQ.delete();
            d0 = doneCount;
            sendFrame(n, 1'b1, lk, 1'b1, ok);
            waitDone(d0 + 1, 20, ok);
            testsRun++;
            if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL rand frame %0d no done got %0d want %0d", f, doneCount, d0 + 1); end
            testsRun++;
            if (wrQ.size() != expQ.size()) begin
                testsFailed++;
                $display("[TB] FAIL rand frame %0d writes got %0d want %0d", f, wrQ.size(), expQ.size());
            end
            for (int i = 0; i < expQ.size(); i++) begin
                wr_t got = '0;
                if (i < wrQ.size()) got = wrQ[i];
                testsRun++;
                if (got !== expQ[i]) begin
                    testsFailed++;
                    $display("[TB] FAIL rand frame %0d write%0d got %h want %h", f, i, got, expQ[i]);
                end
            end
            testsRun++;
            if ({doneLen, doneErr, doneWithWrite} !== {expLen, expErr, expDoneWithWrite}) begin
                testsFailed++;
                $display("[TB] FAIL rand frame %0d status len=%0d err=%b wr=%b want len=%0d err=%b wr=%b",
                         f, doneLen, doneErr, doneWithWrite, expLen, expErr, expDoneWithWrite);
            end
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            testsRun++;
            if ({doneCount == d0 + 1, bus.s_ready, bus.busy} !== 3'b101) begin
                testsFailed++;
                $display("[TB] FAIL rand frame %0d hold dones=%0d ready=%b busy=%b want dones=1 ready=0 busy=1",
                         f, doneCount - d0, bus.s_ready, bus.busy);
            end
            doRelease();
        end
    endtask

`ifdef RX_FRAME_WR16_TIMEOUT_EN
    task automatic test_timeout();
        int d0;
        bit ok;
        beatData[0] = 16'hE001; beatData[1] = 16'hE002;
        wrQ.delete();
        d0 = doneCount;
        sendFrame(2, 1'b0, 2'b11, 1'b0, ok);
        repeat (6) begin @(posedge clk); #1; end
        testsRun++;
        if (doneCount != d0) begin testsFailed++; $display("[TB] FAIL timeout early done got %0d want 0", doneCount - d0); end
        waitDone(d0 + 1, 10, ok);
        testsRun++;
        if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout no done got %0d want %0d", doneCount, d0 + 1); end
        testsRun++;
        if ({doneLen, doneErr, doneWithWrite} !== {LW'(4), 1'b1, 1'b0} || wrQ.size() != 2) begin
            testsFailed++;
            $display("[TB] FAIL timeout status len=%0d err=%b wr=%b writes=%0d want len=4 err=1 wr=0 writes=2",
                     doneLen, doneErr, doneWithWrite, wrQ.size());
        end
        doRelease();
    endtask
`else
    task automatic test_timeout();
        int d0;
        bit ok;
        beatData[0] = 16'hE001; beatData[1] = 16'hE002; beatData[2] = 16'hE003;
        wrQ.delete();
        d0 = doneCount;
        sendFrame(2, 1'b0, 2'b11, 1'b0, ok);
        repeat (20) begin @(posedge clk); #1; end
        testsRun++;
        if (doneCount != d0 || bus.s_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL idle wait dones=%0d ready=%b want dones=0 ready=1", doneCount - d0, bus.s_ready);
        end
        beatData[0] = 16'hE003;
        sendFrame(1, 1'b1, 2'b01, 1'b0, ok);
        waitDone(d0 + 1, 20, ok);
        testsRun++;
        if ({doneLen, doneErr} !== {LW'(5), 1'b0} || wrQ.size() != 3) begin
            testsFailed++;
            $display("[TB] FAIL idle resume len=%0d err=%b writes=%0d want len=5 err=0 writes=3",
                     doneLen, doneErr, wrQ.size());
        end
        doRelease();
    endtask
`endif

    initial begin
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.s_last      = 1'b0;
        bus.s_keep      = 2'b00;
        bus.buf_release = 1'b0;
        test_reset();
        test_three_beat();
        test_single_beat();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
